regbank_wb_scheduler: RTL and testbench



---
 rtl/cpu_pkg.sv | 17 +
 rtl/wb_rr_arbiter.sv | 33 +++
 rtl/regbank_wb_scheduler.sv | 97 +++++++++
 tb/tb_regbank_wb_scheduler.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the register-bank write-back path.
//   NREG        number of architectural registers
//   AW / DW     register address / data widths
//   NOWB_OPCODE opcode that never writes a register
//   RR_ALU/MEM  round-robin pointer encodings (pointer names the next contended winner)
package cpu_pkg;

  localparam int NREG = 16;
  localparam int AW   = 4;
  localparam int DW   = 32;

  localparam logic [3:0] NOWB_OPCODE = 4'b1111;

  localparam logic RR_ALU = 1'b0;
  localparam logic RR_MEM = 1'b1;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter for the register-bank write port.
//   clk, reset            clock, async active-high reset
//   alu_valid, mem_valid  write-back requests
//   alu_grant, mem_grant  one-cycle grants (at most one high)
// The pointer only moves on a contended cycle and then points at the loser,
// so an uncontested requester never steals the other one's turn.
module wb_rr_arbiter
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic alu_valid,
  input  logic mem_valid,
  output logic alu_grant,
  output logic mem_grant
);

  logic rr_ptr;

  always_comb begin
    alu_grant = alu_valid && (!mem_valid || rr_ptr == RR_ALU);
    mem_grant = mem_valid && (!alu_valid || rr_ptr == RR_MEM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= RR_ALU;
    end else if (alu_valid && mem_valid) begin
      rr_ptr <= ~rr_ptr;
    end
  end

endmodule

// File: rtl/regbank_wb_scheduler.sv
// Write-back scheduler and hazard scoreboard for the register bank.
//   issue_*        decode-stage instruction; issue_stall holds it back
//   alu_*, mem_*   write-back requesters (valid/ready handshake)
//   wb_we/dest/din registered write port into the bank
//   busy           per-register "write outstanding" scoreboard
//   sb_error       sticky flag: a write-back hit a register that was not busy
// Stall decisions look only at registered busy. A grant clears its busy bit on
// the same edge the write strobe rises, so a dependent instruction can issue
// in the cycle the bank is written and read the new value afterwards.
module regbank_wb_scheduler #(
  parameter int         NREG        = cpu_pkg::NREG,
  parameter int         AW          = cpu_pkg::AW,
  parameter int         DW          = cpu_pkg::DW,
  parameter logic [3:0] NOWB_OPCODE = cpu_pkg::NOWB_OPCODE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [3:0]      issue_opcode,
  input  logic [AW-1:0]   issue_dest,
  input  logic [AW-1:0]   issue_srcadd1,
  input  logic [AW-1:0]   issue_srcadd2,
  output logic            issue_stall,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_dest,
  input  logic [DW-1:0]   alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_dest,
  input  logic [DW-1:0]   mem_data,
  output logic            wb_we,
  output logic [AW-1:0]   wb_dest,
  output logic [DW-1:0]   wb_din,
  output logic [NREG-1:0] busy,
  output logic            sb_error
);

  logic            grant;
  logic            issue_accept;
  logic [AW-1:0]   win_dest;
  logic [DW-1:0]   win_data;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  wb_rr_arbiter u_arb (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .mem_valid (mem_valid),
    .alu_grant (alu_ready),
    .mem_grant (mem_ready)
  );

  always_comb begin
    issue_stall  = issue_valid &&
                   (busy[issue_srcadd1] || busy[issue_srcadd2] ||
                    (issue_opcode != NOWB_OPCODE && busy[issue_dest]));
    issue_accept = issue_valid && !issue_stall;

    grant    = alu_ready || mem_ready;
    win_dest = alu_ready ? alu_dest : mem_dest;
    win_data = alu_ready ? alu_data : mem_data;

    set_mask = '0;
    if (issue_accept && issue_opcode != NOWB_OPCODE) begin
      set_mask = {{(NREG-1){1'b0}}, 1'b1} << issue_dest;
    end

    clr_mask = '0;
    if (grant) begin
      clr_mask = {{(NREG-1){1'b0}}, 1'b1} << win_dest;
    end
  end

  // Set is applied after clear so a forced same-bit collision leaves it busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= '0;
      wb_we    <= 1'b0;
      wb_dest  <= '0;
      wb_din   <= '0;
      sb_error <= 1'b0;
    end else begin
      busy  <= (busy & ~clr_mask) | set_mask;
      wb_we <= grant;
      if (grant) begin
        wb_dest <= win_dest;
        wb_din  <= win_data;
        if (!busy[win_dest]) begin
          sb_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regbank_wb_scheduler.sv
module tb_regbank_wb_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [3:0]  issue_opcode;
  logic [3:0]  issue_dest, issue_srcadd1, issue_srcadd2;
  logic        issue_stall;
  logic        alu_valid, alu_ready;
  logic [3:0]  alu_dest;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [3:0]  mem_dest;
  logic [31:0] mem_data;
  logic        wb_we;
  logic [3:0]  wb_dest;
  logic [31:0] wb_din;
  logic [15:0] busy;
  logic        sb_error;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a set of pending registers, a "whose turn on contention"
  // flag, a sticky error bit and the expected contents of the write port.
  bit          m_pending[16];
  bit          m_alu_turn;
  bit          m_err;
  bit          exp_we;
  logic [3:0]  exp_dest;
  logic [31:0] exp_din;
  bit          last_alu_won, last_mem_won;

  regbank_wb_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_opcode  (issue_opcode),
    .issue_dest    (issue_dest),
    .issue_srcadd1 (issue_srcadd1),
    .issue_srcadd2 (issue_srcadd2),
    .issue_stall   (issue_stall),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_dest      (alu_dest),
    .alu_data      (alu_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_dest      (mem_dest),
    .mem_data      (mem_data),
    .wb_we         (wb_we),
    .wb_dest       (wb_dest),
    .wb_din        (wb_din),
    .busy          (busy),
    .sb_error      (sb_error)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m_busy_vec();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_pending[i];
    return v;
  endfunction

  function automatic bit m_stall();
    return issue_valid && (m_pending[issue_srcadd1] || m_pending[issue_srcadd2] ||
           (issue_opcode != 4'hF && m_pending[issue_dest]));
  endfunction

  function automatic bit m_alu_wins();
    return alu_valid && (!mem_valid || m_alu_turn);
  endfunction

  function automatic bit m_mem_wins();
    return mem_valid && !(alu_valid && (!mem_valid || m_alu_turn));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_pending[i] = 1'b0;
    m_alu_turn = 1'b1;
    m_err      = 1'b0;
    exp_we     = 1'b0;
    exp_dest   = '0;
    exp_din    = '0;
  endtask

  // Predict the next edge from the inputs currently driven, then advance to #1 after it.
  task automatic tick();
    bit aw, mw, acc;
    logic [3:0] d;
    aw  = m_alu_wins();
    mw  = m_mem_wins();
    acc = issue_valid && !m_stall();
    if (alu_valid && mem_valid) m_alu_turn = mw;
    exp_we = aw || mw;
    if (aw || mw) begin
      d        = aw ? alu_dest : mem_dest;
      exp_dest = d;
      exp_din  = aw ? alu_data : mem_data;
      if (!m_pending[d]) m_err = 1'b1;
      m_pending[d] = 1'b0;
    end
    if (acc && issue_opcode != 4'hF) m_pending[issue_dest] = 1'b1;
    last_alu_won = aw;
    last_mem_won = mw;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_opcode = 0; issue_dest = 0; issue_srcadd1 = 0; issue_srcadd2 = 0;
    alu_valid = 0; alu_dest = 0; alu_data = 0;
    mem_valid = 0; mem_dest = 0; mem_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] d,
                       input logic [3:0] s1, input logic [3:0] s2);
    issue_valid = 1; issue_opcode = op; issue_dest = d; issue_srcadd1 = s1; issue_srcadd2 = s2;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    model_clear();
    #2;
    n_checks++;
    if ({wb_we, wb_dest, wb_din, busy, sb_error} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got we=%0b dest=%0d din=%h busy=%h err=%0b, want all 0",
               wb_we, wb_dest, wb_din, busy, sb_error);
    end
    n_checks++;
    if ({issue_stall, alu_ready, mem_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_comb: got stall/alu_rdy/mem_rdy=%b, want 000",
               {issue_stall, alu_ready, mem_ready});
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_issue_wb();
    do_reset();
    issue(4'h0, 4'd3, 4'd1, 4'd2);
    @(negedge clk);
    n_checks++;
    if (issue_stall !== 1'b0) begin
      n_fail++; $display("FAIL add_stall: got %0b want 0", issue_stall);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (busy !== 16'h0008) begin
      n_fail++; $display("FAIL add_busy: got %h want 0008", busy);
    end
    alu_valid = 1; alu_dest = 4'd3; alu_data = 32'h0000_00AA;
    @(negedge clk);
    n_checks++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
      n_fail++; $display("FAIL alu_grant: got alu=%0b mem=%0b want 1 0", alu_ready, mem_ready);
    end
    tick();
    alu_valid = 0;
    n_checks++;
    if (wb_we !== 1'b1 || wb_dest !== 4'd3 || wb_din !== 32'hAA || busy !== 16'h0) begin
      n_fail++;
      $display("FAIL alu_wb: got we=%0b dest=%0d din=%h busy=%h want 1 3 000000aa 0000",
               wb_we, wb_dest, wb_din, busy);
    end
    tick();
    n_checks++;
    if (wb_we !== 1'b0 || wb_dest !== 4'd3 || wb_din !== 32'hAA) begin
      n_fail++;
      $display("FAIL wb_hold: got we=%0b dest=%0d din=%h want 0 3 000000aa", wb_we, wb_dest, wb_din);
    end
  endtask

  task automatic test_raw_stall();
    do_reset();
    issue(4'h1, 4'd5, 4'd0, 4'd0);
    tick();
    issue(4'h2, 4'd6, 4'd4, 4'd5);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (issue_stall !== 1'b1) begin
        n_fail++; $display("FAIL raw_stall_%0d: got %0b want 1", i, issue_stall);
      end
      tick();
    end
    // Grant of r5 this cycle: stall still seen, registered busy not yet cleared.
    alu_valid = 1; alu_dest = 4'd5; alu_data = 32'h5555_0005;
    @(negedge clk);
    n_checks++;
    if (issue_stall !== 1'b1 || alu_ready !== 1'b1) begin
      n_fail++; $display("FAIL raw_grant_cycle: got stall=%0b rdy=%0b want 1 1", issue_stall, alu_ready);
    end
    tick();
    alu_valid = 0;
    @(negedge clk);
    n_checks++;
    if (issue_stall !== 1'b0) begin
      n_fail++; $display("FAIL raw_release: got %0b want 0", issue_stall);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (busy !== 16'h0040) begin
      n_fail++; $display("FAIL raw_accept_busy: got %h want 0040", busy);
    end
  endtask

  task automatic test_contention();
    int seq[4] = '{1, 2, 1, 2};
    do_reset();
    issue(4'h0, 4'd1, 4'd0, 4'd0);
    tick();
    issue(4'h0, 4'd2, 4'd0, 4'd0);
    tick();
    idle_inputs();
    alu_valid = 1; alu_dest = 4'd1; alu_data = 32'd1;
    mem_valid = 1; mem_dest = 4'd2; mem_data = 32'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (alu_ready !== m_alu_wins() || mem_ready !== m_mem_wins()) begin
        n_fail++;
        $display("FAIL contend_ready_%0d: got alu=%0b mem=%0b want %0b %0b",
                 i, alu_ready, mem_ready, m_alu_wins(), m_mem_wins());
      end
      tick();
      n_checks++;
      if (wb_we !== 1'b1 || wb_dest !== 4'(seq[i]) || wb_din !== 32'(seq[i])) begin
        n_fail++;
        $display("FAIL contend_seq_%0d: got we=%0b dest=%0d din=%0d want 1 %0d %0d",
                 i, wb_we, wb_dest, wb_din, seq[i], seq[i]);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_nowb();
    do_reset();
    issue(4'h3, 4'd7, 4'd0, 4'd0);
    tick();
    issue(4'hF, 4'd7, 4'd8, 4'd9);
    @(negedge clk);
    n_checks++;
    if (issue_stall !== 1'b0) begin
      n_fail++; $display("FAIL nowb_stall: got %0b want 0", issue_stall);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (busy !== 16'h0080) begin
      n_fail++; $display("FAIL nowb_busy: got %h want 0080", busy);
    end
    issue(4'h3, 4'd7, 4'd0, 4'd0);
    @(negedge clk);
    n_checks++;
    if (issue_stall !== 1'b1) begin
      n_fail++; $display("FAIL waw_stall: got %0b want 1", issue_stall);
    end
    idle_inputs();
  endtask

  task automatic test_spurious();
    do_reset();
    mem_valid = 1; mem_dest = 4'd9; mem_data = 32'h1234_5678;
    @(negedge clk);
    n_checks++;
    if (mem_ready !== 1'b1) begin
      n_fail++; $display("FAIL spur_ready: got %0b want 1", mem_ready);
    end
    tick();
    mem_valid = 0;
    n_checks++;
    if (wb_we !== 1'b1 || wb_dest !== 4'd9 || wb_din !== 32'h1234_5678 || sb_error !== 1'b1) begin
      n_fail++;
      $display("FAIL spur_write: got we=%0b dest=%0d din=%h err=%0b want 1 9 12345678 1",
               wb_we, wb_dest, wb_din, sb_error);
    end
    repeat (5) tick();
    n_checks++;
    if (sb_error !== 1'b1) begin
      n_fail++; $display("FAIL spur_sticky: got %0b want 1", sb_error);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (sb_error !== 1'b0) begin
      n_fail++; $display("FAIL spur_reset: got %0b want 0", sb_error);
    end
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    issue(4'h0, 4'd2, 4'd0, 4'd0);
    tick();
    issue(4'h0, 4'd5, 4'd0, 4'd0);
    tick();
    idle_inputs();
    n_checks++;
    if (busy !== 16'h0024) begin
      n_fail++; $display("FAIL mid_setup_busy: got %h want 0024", busy);
    end
    alu_valid = 1; alu_dest = 4'd2; alu_data = 32'hDEAD_0002;
    tick();
    alu_dest = 4'd5; alu_data = 32'hDEAD_0005;
    n_checks++;
    if (wb_we !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre_we: got %0b want 1", wb_we);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({wb_we, wb_dest, wb_din, busy, sb_error} !== '0) begin
      n_fail++;
      $display("FAIL mid_async: got we=%0b dest=%0d din=%h busy=%h err=%0b want all 0",
               wb_we, wb_dest, wb_din, busy, sb_error);
    end
    model_clear();
    @(posedge clk);
    #1;
    n_checks++;
    if (wb_we !== 1'b0 || busy !== 16'h0) begin
      n_fail++; $display("FAIL mid_held: got we=%0b busy=%h want 0 0000", wb_we, busy);
    end
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      issue_valid   = ($urandom_range(0, 2) != 0);
      issue_opcode  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      issue_dest    = 4'($urandom_range(0, 7));
      issue_srcadd1 = 4'($urandom_range(0, 7));
      issue_srcadd2 = 4'($urandom_range(0, 7));
      if (!alu_valid || last_alu_won) begin
        alu_valid = ($urandom_range(0, 1) == 1);
        alu_dest  = 4'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      if (!mem_valid || last_mem_won) begin
        mem_valid = ($urandom_range(0, 1) == 1);
        mem_dest  = 4'($urandom_range(0, 7));
        mem_data  = $urandom;
      end
      @(negedge clk);
      n_checks++;
      if (issue_stall !== m_stall() || alu_ready !== m_alu_wins() || mem_ready !== m_mem_wins()) begin
        n_fail++;
        $display("FAIL rand_comb cyc%0d: got stall=%0b alu=%0b mem=%0b want %0b %0b %0b", cyc,
                 issue_stall, alu_ready, mem_ready, m_stall(), m_alu_wins(), m_mem_wins());
      end
      tick();
      n_checks++;
      if (wb_we !== exp_we || wb_dest !== exp_dest || wb_din !== exp_din ||
          busy !== m_busy_vec() || sb_error !== m_err) begin
        n_fail++;
        $display("FAIL rand_reg cyc%0d: got we=%0b dest=%0d din=%h busy=%h err=%0b want %0b %0d %h %h %0b",
                 cyc, wb_we, wb_dest, wb_din, busy, sb_error,
                 exp_we, exp_dest, exp_din, m_busy_vec(), m_err);
      end
    end
    idle_inputs();
  endtask

  initial begin
    last_alu_won = 0;
    last_mem_won = 0;
    test_reset();
    test_issue_wb();
    test_raw_stall();
    test_contention();
    test_nowb();
    test_spurious();
    test_reset_midstream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
